uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Standalone UART receive front-end for serial data produced by our uart_tx: 8N1 framing, LSB first, line idles high.
- Mid-bit sampling driven by a bit-period counter.
- Received bytes go into a small first-word-fall-through FIFO that the host drains with rd_en.
- Reports framing errors and FIFO overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 434, clk_rx cycles per bit (50 MHz / 115200); minimum 4.
- FIFO_DEPTH, 4, number of byte entries; power of two, minimum 2.

Ports:
- clk_rx  input  1  receive clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line, asynchronous to clk_rx.
- rd_en  input  1  pops the FIFO head when data_valid=1.
- data_out_rx  output  8  FIFO head byte; valid only while data_valid=1.
- data_valid  output  1  FIFO not empty.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, all counters 0, FIFO empty.
  - Both synchronizer flops set to 1.
  - data_out_rx=8'h00, data_valid=0, frame_err=0, overrun=0.
- Synchronizer:
  - rx_in passes through 2 flops to give rx_s.
  - A third flop, rx_d, holds the previous rx_s.
  - Falling edge is defined as rx_d=1 and rx_s=0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a falling edge: clear bit counter, go to START.
  - A line held low (break) does not retrigger; a fresh high-to-low edge is required.
- START:
  - Count CLKS_PER_BIT/2 - 1 cycles, then sample rx_s.
  - rx_s=0: clear counter, go to DATA.
  - rx_s=1: false start; go to IDLE with no error reported.
- DATA:
  - Sample rx_s every CLKS_PER_BIT cycles into the shift register, LSB first (first sampled bit becomes bit 0).
  - After 8 samples, go to STOP.
- STOP:
  - Sample after CLKS_PER_BIT cycles, then go to IDLE.
  - rx_s=1 and FIFO not full: push the byte.
  - rx_s=1 and FIFO full: drop the byte, overrun=1 for one cycle.
  - rx_s=0: drop the byte, frame_err=1 for one cycle; FIFO untouched.
- Latency: data_valid rises on the cycle after the stop-bit sample edge (FIFO previously empty).
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits; wrap-around is natural modulo.
  - Full when pointer MSBs differ and the low bits are equal.
  - data_out_rx is combinational from the head entry (FWFT).
  - rd_en while empty is ignored: no pointer change, no error.
  - Simultaneous push and pop while full: the pop is taken first, the push is accepted, no overrun, count unchanged.
  - Simultaneous push and pop while empty: the push is accepted; the pop is ignored because data_valid was 0.
- Reset asserted mid-frame aborts the frame, empties the FIFO and suppresses any pulse.
- After rst deasserts, reception starts only on the next falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled one CLKS_PER_BIT after the last data bit.
  - Even parity: the XOR of 8 data bits and the parity bit must be 0.
  - New output port parity_err (1 bit, reset 0) pulses for one cycle at the stop-sample cycle when parity fails; the byte is dropped.
  - If both stop and parity are bad, only frame_err pulses.
- Undefined: no PARITY state and no parity_err port; 8N1 framing only.

Test Plan:
- CLKS_PER_BIT=8. Send 8'hA5 8N1 -> data_valid=1 one cycle after the stop sample, data_out_rx=8'hA5. Pulse rd_en -> data_valid=0.
- Send 8'h3C with stop bit 0 -> frame_err pulses once; data_valid stays 0. Then send 8'h01 correctly -> received as 8'h01.
- Low glitch on rx_in of 2 clk_rx cycles -> FSM returns to IDLE; no byte, no pulses.
- Send 5 bytes 8'h10 to 8'h14 without reading (depth 4) -> overrun pulses on the 5th. Reads return 10,11,12,13, then data_valid=0.
- With the FIFO full, assert rd_en in the same cycle as the 5th stop-sample push -> no overrun. Reads return 11,12,13,14.
- Assert rst mid-DATA of a byte 8'hFF -> outputs return to reset values. The next frame 8'h5A is received correctly. With UART_RX_PARITY_EN defined, 8'h5A sent with parity bit 1 -> parity_err pulses and no byte is stored.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a first-word-fall-through byte FIFO.
// Optional even-parity framing is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_rx,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       rd_en,
  output logic [7:0] data_out_rx,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] clk_cnt, clk_cnt_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shift, shift_next;
  logic          rx_meta, rx_s, rx_d;
  logic          push_req, frame_bad;
`ifdef UART_RX_PARITY_EN
  logic          par_bit, par_bit_next;
  logic          par_bad;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, push, pop;

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  always_ff @(posedge clk_rx or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk_rx or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt + 1'b1;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    push_req     = 1'b0;
    frame_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_next = par_bit;
    par_bad      = 1'b0;
`endif
    case (state)
      IDLE: begin
        clk_cnt_next = '0;
        if (rx_d && !rx_s) begin
          bit_cnt_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (clk_cnt == HALF_CNT) begin
          clk_cnt_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        // New bits enter at the MSB so the first bit ends up in bit 0.
        if (clk_cnt == FULL_CNT) begin
          clk_cnt_next = '0;
          shift_next   = {rx_s, shift[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == FULL_CNT) begin
          clk_cnt_next = '0;
          par_bit_next = rx_s;
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == FULL_CNT) begin
          clk_cnt_next = '0;
          state_next   = IDLE;
          if (!rx_s)
            frame_bad = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (^{shift, par_bit})
            par_bad = 1'b1;
`endif
          else
            push_req = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign data_valid  = (wr_ptr != rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop         = rd_en && data_valid;
  assign push        = push_req && (!full || pop);
  assign data_out_rx = data_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk_rx or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      frame_err <= frame_bad;
      overrun   <= push_req && full && !pop;
`ifdef UART_RX_PARITY_EN
      parity_err <= par_bad;
`endif
    end
  end

  always_ff @(posedge clk_rx) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shift;
  end

endmodule
